ft245_device_model: RTL
=======================

FT245_DEVICE_MODEL -- requirements
Module: ft245_device_model

Interface
REQ-001 Parameters: DEPTH, 16, entries per FIFO (power of 2); RXF_RECOVERY, 2, clocks RXF_N held high after each read; TXE_RECOVERY, 2, clocks TXE_N held high after each write.
REQ-002 CLK  in  1  system clock; all device-side and host-side signals are synchronous to it.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 USB_RXF_N  out  1  low = byte available for FPGA to read.
REQ-005 USB_TXE_N  out  1  low = space available for FPGA to write.
REQ-006 USB_RD_N  in  1  FPGA read strobe, active-low.
REQ-007 USB_WR  in  1  FPGA write strobe, active-low (idle 1).
REQ-008 USB_DATA_TO_FPGA  out  8  RX FIFO head byte.
REQ-009 USB_DATA_FROM_FPGA  in  8  byte written by FPGA.
REQ-010 HOST_TX_VALID/HOST_TX_READY/HOST_TX_DATA  in/out/in  1/1/8  host pushes bytes into RX FIFO.
REQ-011 HOST_RX_VALID/HOST_RX_READY/HOST_RX_DATA  out/in/out  1/1/8  host pops bytes from TX FIFO.
REQ-012 RD_ERR, WR_ERR  out  1  sticky protocol-violation flags.

Function
REQ-013 Strobe edges SHALL be detected by comparing each strobe to its registered previous value (no synchronizers; same clock domain).
REQ-014 RX FSM states SHALL be RX_IDLE, RX_READ, RX_RECOVER.
REQ-015 RX_IDLE: USB_RXF_N SHALL be low iff RX FIFO non-empty; on a falling USB_RD_N with RXF_N low, go to RX_READ.
REQ-016 USB_DATA_TO_FPGA SHALL show the RX FIFO head (show-ahead) at all times when RX FIFO is non-empty and SHALL hold it stable through RX_READ; 8'h00 when empty.
REQ-017 RX_READ: on rising USB_RD_N, pop one byte, drive USB_RXF_N high on the next clock, go to RX_RECOVER.
REQ-018 RX_RECOVER: hold USB_RXF_N high for RXF_RECOVERY clocks, then return to RX_IDLE.
REQ-019 A falling USB_RD_N while USB_RXF_N is high SHALL pop nothing and set RD_ERR.
REQ-020 TX FSM states SHALL be TX_IDLE, TX_BUSY, TX_RECOVER.
REQ-021 TX_IDLE: USB_TXE_N SHALL be low iff TX FIFO not full; on the clock USB_WR is first sampled 0 with TXE_N low, push USB_DATA_FROM_FPGA, drive USB_TXE_N high next clock, go to TX_BUSY.
REQ-022 TX_BUSY: hold USB_TXE_N high until USB_WR sampled 1, then TX_RECOVER for TXE_RECOVERY clocks, then TX_IDLE.
REQ-023 A falling USB_WR while USB_TXE_N is high SHALL discard the byte and set WR_ERR.
REQ-024 HOST_TX_READY SHALL equal RX FIFO not full; push occurs on HOST_TX_VALID and HOST_TX_READY.
REQ-025 HOST_RX_VALID SHALL equal TX FIFO non-empty with HOST_RX_DATA = head; pop occurs on HOST_RX_VALID and HOST_RX_READY.
REQ-026 Simultaneous push and pop on one FIFO SHALL both take effect, occupancy unchanged; pointers SHALL wrap modulo DEPTH with an extra bit distinguishing full from empty.
REQ-027 Full FIFO SHALL refuse pushes without corruption; empty FIFO SHALL refuse pops.

Reset
REQ-028 During reset: both FIFOs empty, both FSMs idle, USB_RXF_N=1, USB_TXE_N=1, USB_DATA_TO_FPGA=8'h00, HOST_TX_READY=0, HOST_RX_VALID=0, RD_ERR=WR_ERR=0, strobe history registers=1.
REQ-029 After RST_N release, USB_TXE_N SHALL go low and HOST_TX_READY high on the first clock edge.
REQ-030 Reset mid-transfer SHALL abandon the transfer; no partial byte is retained.

Structure
REQ-031 FSM state encodings and default parameter values SHALL live in the shared ft245 definitions include used by the FT245 blocks.
REQ-032 One sub-module, ft245_sync_fifo (8-bit, DEPTH-parameterized, show-ahead, full/empty/count), SHALL be instantiated twice (RX and TX).

Verification
REQ-033 Host pushes 8'hA5; FPGA-side master reads -> RXF_N low within 2 clocks, master captures 8'hA5, RXF_N high ≥2 clocks after RD_N rises, FIFO empty.
REQ-034 Master writes 8'h3C with WRITE_EN -> TXE_N rises next clock after WR low, master completes, host pops 8'h3C.
REQ-035 Host pushes 16 bytes 8'h00..8'h0F, 17th push -> HOST_TX_READY low after 16th; master reads back 8'h00..8'h0F in order.
REQ-036 Master writes 16 bytes, no host pops -> TXE_N stays high after 16th; forced WR pulse sets WR_ERR, TX count stays 16.
REQ-037 RD_N pulsed low with RX FIFO empty -> RD_ERR=1, USB_DATA_TO_FPGA=8'h00, no state change.
REQ-038 RST_N asserted while RD_N low with 3 bytes queued -> RXF_N=1, FIFOs empty; after release TXE_N low, RXF_N stays high.

Source files
------------

// File: rtl/ft245_pkg.sv
// Shared FT245 definitions: FSM state encodings and default parameters.
// Imported by the FIFO and the device model.
package ft245_pkg;

  localparam int DEF_DEPTH        = 16;
  localparam int DEF_RXF_RECOVERY = 2;
  localparam int DEF_TXE_RECOVERY = 2;

  // Width of the recovery-period counters.
  localparam int REC_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_READ,
    RX_RECOVER
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_BUSY,
    TX_RECOVER
  } tx_state_t;

endpackage

// File: rtl/ft245_sync_fifo.sv
// 8-bit show-ahead synchronous FIFO with full/empty/count.
// Ports: clk, rst_n, push/push_data, pop, head, full, empty, count.
module ft245_sync_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ft245_device_model.sv
// FT245 FIFO-mode device model: host-side byte streams <-> FPGA strobes.
// Ports: CLK, RST_N, USB_* device pins, HOST_TX_*/HOST_RX_*, RD_ERR/WR_ERR.
module ft245_device_model
  import ft245_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int RXF_RECOVERY = DEF_RXF_RECOVERY,
  parameter int TXE_RECOVERY = DEF_TXE_RECOVERY
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic       USB_RXF_N,
  output logic       USB_TXE_N,
  input  logic       USB_RD_N,
  input  logic       USB_WR,
  output logic [7:0] USB_DATA_TO_FPGA,
  input  logic [7:0] USB_DATA_FROM_FPGA,
  input  logic       HOST_TX_VALID,
  output logic       HOST_TX_READY,
  input  logic [7:0] HOST_TX_DATA,
  output logic       HOST_RX_VALID,
  input  logic       HOST_RX_READY,
  output logic [7:0] HOST_RX_DATA,
  output logic       RD_ERR,
  output logic       WR_ERR
);

  localparam int AW = $clog2(DEPTH);

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [REC_W-1:0] rx_cnt, rx_cnt_d;
  logic [REC_W-1:0] tx_cnt, tx_cnt_d;

  logic rd_q, wr_q;
  logic rd_fall, rd_rise, wr_fall;
  logic rxf_n_q, rxf_n_d;
  logic txe_n_q, txe_n_d;
  logic rd_err_q, wr_err_q;
  logic alive;

  logic       rx_push, rx_pop;
  logic       tx_push, tx_pop;
  logic [7:0] rx_head, tx_head;
  logic       rx_full, rx_empty;
  logic       tx_full, tx_empty;
  logic [AW:0] rx_count, tx_count;
  logic       unused_cnt;

  ft245_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (rx_push),
    .push_data (HOST_TX_DATA),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  ft245_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (tx_push),
    .push_data (USB_DATA_FROM_FPGA),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign unused_cnt = ^{rx_count, tx_count};

  // Strobes share CLK with the model, so edges come
  // straight from a one-deep history register.
  assign rd_fall = rd_q & ~USB_RD_N;
  assign rd_rise = ~rd_q & USB_RD_N;
  assign wr_fall = wr_q & ~USB_WR;

  // alive is low only until the first edge after reset,
  // keeping the host side quiet during reset.
  assign HOST_TX_READY = alive & ~rx_full;
  assign rx_push       = HOST_TX_VALID & HOST_TX_READY;
  assign HOST_RX_VALID = ~tx_empty;
  assign HOST_RX_DATA  = tx_empty ? 8'h00 : tx_head;
  assign tx_pop        = HOST_RX_VALID & HOST_RX_READY;

  assign USB_DATA_TO_FPGA = rx_empty ? 8'h00 : rx_head;
  assign USB_RXF_N        = rxf_n_q;
  assign USB_TXE_N        = txe_n_q;
  assign RD_ERR           = rd_err_q;
  assign WR_ERR           = wr_err_q;

  always_comb begin
    rx_next  = rx_state;
    rx_cnt_d = rx_cnt;
    rxf_n_d  = 1'b1;
    rx_pop   = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rxf_n_d = rx_empty;
        if (rd_fall && !rxf_n_q)
          rx_next = RX_READ;
      end
      RX_READ: begin
        // Head byte stays put until the strobe ends.
        rxf_n_d = 1'b0;
        if (rd_rise) begin
          rx_pop   = 1'b1;
          rxf_n_d  = 1'b1;
          rx_cnt_d = '0;
          rx_next  = RX_RECOVER;
        end
      end
      RX_RECOVER: begin
        if (rx_cnt == REC_W'(RXF_RECOVERY - 1))
          rx_next = RX_IDLE;
        else
          rx_cnt_d = rx_cnt + 1'b1;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_next  = tx_state;
    tx_cnt_d = tx_cnt;
    txe_n_d  = 1'b1;
    tx_push  = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        txe_n_d = tx_full;
        if (wr_fall && !txe_n_q) begin
          tx_push = 1'b1;
          txe_n_d = 1'b1;
          tx_next = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (USB_WR) begin
          tx_cnt_d = '0;
          tx_next  = TX_RECOVER;
        end
      end
      TX_RECOVER: begin
        if (tx_cnt == REC_W'(TXE_RECOVERY - 1))
          tx_next = TX_IDLE;
        else
          tx_cnt_d = tx_cnt + 1'b1;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      rxf_n_q  <= 1'b1;
      txe_n_q  <= 1'b1;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
      alive    <= 1'b0;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
      rx_cnt   <= rx_cnt_d;
      tx_cnt   <= tx_cnt_d;
      rd_q     <= USB_RD_N;
      wr_q     <= USB_WR;
      rxf_n_q  <= rxf_n_d;
      txe_n_q  <= txe_n_d;
      alive    <= 1'b1;
      // A strobe while the flag is high is a protocol
      // violation: nothing moves, the error sticks.
      if (rd_fall && rxf_n_q) rd_err_q <= 1'b1;
      if (wr_fall && txe_n_q) wr_err_q <= 1'b1;
    end
  end

endmodule
